multi_target_click: RTL and testbench

Parametrised click-hit detector for the game datapath. It evaluates a mouse click against up to NUM_TARGETS square targets and reports the outcome to game logic through a valid/ready handshake: hit or miss, the winning target index, and the full hit vector. It also keeps saturating hit/miss tallies. It sits between the mouse/PS2 coordinate front end and the score/game-control FSM, and supersedes the single-square click check.

---
 rtl/click_pkg.sv | 13 +
 rtl/target_hit_compare.sv | 32 +++
 rtl/multi_target_click.sv | 178 +++++++++++++++++
 tb/tb_multi_target_click.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/click_pkg.sv
// Shared types and defaults for the click-hit detector.
// FSM state encoding and the default coordinate width.
package click_pkg;

    localparam int COORD_W_DEF = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/target_hit_compare.sv
// Purpose: combinational inclusive bounds test of one square target against the mouse position.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the parent holds the snapshot stable while the result is used.
module target_hit_compare
    import click_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int SIZE    = 10
) (
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_mx,
    input  logic [COORD_W-1:0] i_my,
    input  logic               i_en,
    output logic               o_hit
);

    logic [COORD_W:0] w_x_max;
    logic [COORD_W:0] w_y_max;
    logic             w_in_x;
    logic             w_in_y;

    // One extra bit keeps the far edge from wrapping for targets near the max coordinate.
    assign w_x_max = {1'b0, i_x0} + (COORD_W+1)'(SIZE);
    assign w_y_max = {1'b0, i_y0} + (COORD_W+1)'(SIZE);

    assign w_in_x = (i_mx >= i_x0) && ({1'b0, i_mx} <= w_x_max);
    assign w_in_y = (i_my >= i_y0) && ({1'b0, i_my} <= w_y_max);

    assign o_hit = w_in_x && w_in_y && i_en;

endmodule

// File: rtl/multi_target_click.sv
// Purpose: snapshot a click, test it against NUM_TARGETS squares, report hit/miss and keep tallies.
// Latency: click edge on edge N -> result and counters registered on edge N+1, seen by the consumer at N+2.
// Backpressure: result held in REPORT until hit_ready; clicks arriving while busy are dropped and flagged.
module multi_target_click
    import click_pkg::*;
#(
    parameter  int NUM_TARGETS = 4,
    parameter  int SIZE        = 10,
    parameter  int COORD_W     = COORD_W_DEF,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mouse_click,
    input  logic [COORD_W-1:0]             mouse_x,
    input  logic [COORD_W-1:0]             mouse_y,
    input  logic [NUM_TARGETS*COORD_W-1:0] target_x0,
    input  logic [NUM_TARGETS*COORD_W-1:0] target_y0,
    input  logic [NUM_TARGETS-1:0]         target_en,
    output logic                           hit_valid,
    input  logic                           hit_ready,
    output logic                           hit,
    output logic [IDX_W-1:0]               hit_idx,
    output logic [NUM_TARGETS-1:0]         hit_vec,
    output logic [CNT_W-1:0]               hit_count,
    output logic [CNT_W-1:0]               miss_count,
    input  logic                           clear_counts,
    output logic                           click_dropped
);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_click_q;
    logic                           w_click_evt;
    logic                           w_snap;
    logic                           w_eval;

    logic [COORD_W-1:0]             r_mx;
    logic [COORD_W-1:0]             r_my;
    logic [NUM_TARGETS*COORD_W-1:0] r_tx;
    logic [NUM_TARGETS*COORD_W-1:0] r_ty;
    logic [NUM_TARGETS-1:0]         r_en;

    logic [NUM_TARGETS-1:0]         w_hit_vec;
    logic [IDX_W-1:0]               w_hit_idx;
    logic                           w_hit_any;

    logic [NUM_TARGETS-1:0]         r_hit_vec;
    logic                           r_hit;
    logic [IDX_W-1:0]               r_hit_idx;
    logic [CNT_W-1:0]               r_hit_cnt;
    logic [CNT_W-1:0]               r_miss_cnt;
    logic                           r_dropped;

    assign w_click_evt = mouse_click && !r_click_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_click_q <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_click_q <= mouse_click;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        w_eval      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_click_evt) begin
                    w_snap      = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                w_eval      = 1'b1;
                w_state_nxt = REPORT;
            end
            REPORT: begin
                if (hit_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mx <= '0;
            r_my <= '0;
            r_tx <= '0;
            r_ty <= '0;
            r_en <= '0;
        end else if (w_snap) begin
            r_mx <= mouse_x;
            r_my <= mouse_y;
            r_tx <= target_x0;
            r_ty <= target_y0;
            r_en <= target_en;
        end
    end

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_tgt
        target_hit_compare #(
            .COORD_W (COORD_W),
            .SIZE    (SIZE)
        ) u_cmp (
            .i_x0  (r_tx[g*COORD_W +: COORD_W]),
            .i_y0  (r_ty[g*COORD_W +: COORD_W]),
            .i_mx  (r_mx),
            .i_my  (r_my),
            .i_en  (r_en[g]),
            .o_hit (w_hit_vec[g])
        );
    end

    // Scan high to low so the lowest set index wins.
    always_comb begin
        w_hit_idx = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_hit_any = |w_hit_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_vec <= '0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
        end else if (w_eval) begin
            r_hit_vec <= w_hit_vec;
            r_hit     <= w_hit_any;
            r_hit_idx <= w_hit_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (clear_counts) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_eval) begin
            if (w_hit_any) begin
                if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end else begin
                if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_click_evt && (r_state != IDLE);
        end
    end

    assign hit_valid     = (r_state == REPORT);
    assign hit           = r_hit;
    assign hit_idx       = r_hit_idx;
    assign hit_vec       = r_hit_vec;
    assign hit_count     = r_hit_cnt;
    assign miss_count    = r_miss_cnt;
    assign click_dropped = r_dropped;

endmodule

// File: tb/tb_multi_target_click.sv
// Directed bench for multi_target_click: 4 targets, SIZE 10, 11-bit coordinates, 2-bit tallies.
module tb_multi_target_click;

    localparam int NT = 4;
    localparam int CW = 11;
    localparam int KW = 2;

    logic             clk;
    logic             reset;
    logic             mouse_click;
    logic [CW-1:0]    mouse_x;
    logic [CW-1:0]    mouse_y;
    logic [NT*CW-1:0] target_x0;
    logic [NT*CW-1:0] target_y0;
    logic [NT-1:0]    target_en;
    logic             hit_valid;
    logic             hit_ready;
    logic             hit;
    logic [1:0]       hit_idx;
    logic [NT-1:0]    hit_vec;
    logic [KW-1:0]    hit_count;
    logic [KW-1:0]    miss_count;
    logic             clear_counts;
    logic             click_dropped;

    int checks = 0;
    int errors = 0;
    int n_valid;

    multi_target_click #(
        .NUM_TARGETS (NT),
        .SIZE        (10),
        .COORD_W     (CW),
        .CNT_W       (KW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mouse_click   (mouse_click),
        .mouse_x       (mouse_x),
        .mouse_y       (mouse_y),
        .target_x0     (target_x0),
        .target_y0     (target_y0),
        .target_en     (target_en),
        .hit_valid     (hit_valid),
        .hit_ready     (hit_ready),
        .hit           (hit),
        .hit_idx       (hit_idx),
        .hit_vec       (hit_vec),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .clear_counts  (clear_counts),
        .click_dropped (click_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_tgt(input int i, input int x, input int y);
        target_x0[i*CW +: CW] = CW'(x);
        target_y0[i*CW +: CW] = CW'(y);
    endtask

    task automatic all_far();
        for (int i = 0; i < NT; i++) set_tgt(i, 300, 300);
    endtask

    // Rising click on edge N, released afterwards; returns at the negedge after N+1 (REPORT).
    task automatic do_click();
        mouse_click = 1'b1;
        @(negedge clk);
        mouse_click = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        mouse_click  = 1'b0;
        mouse_x      = '0;
        mouse_y      = '0;
        target_x0    = '0;
        target_y0    = '0;
        target_en    = 4'hF;
        hit_ready    = 1'b1;
        clear_counts = 1'b0;
        repeat (2) @(negedge clk);

        check_val("rst_valid", hit_valid, 0);
        check_val("rst_hit", hit, 0);
        check_val("rst_idx", hit_idx, 0);
        check_val("rst_vec", hit_vec, 0);
        check_val("rst_hcnt", hit_count, 0);
        check_val("rst_mcnt", miss_count, 0);
        check_val("rst_drop", click_dropped, 0);

        reset = 1'b1;
        @(negedge clk);

        // single hit on target 2
        all_far();
        set_tgt(2, 50, 50);
        mouse_x = 55; mouse_y = 60;
        mouse_click = 1'b1;
        @(negedge clk);
        check_val("t1_valid_n1", hit_valid, 0);
        mouse_click = 1'b0;
        @(negedge clk);
        check_val("t1_valid", hit_valid, 1);
        check_val("t1_hit", hit, 1);
        check_val("t1_idx", hit_idx, 2);
        check_val("t1_vec", hit_vec, 4'b0100);
        check_val("t1_hcnt", hit_count, 1);
        check_val("t1_mcnt", miss_count, 0);
        @(negedge clk);
        check_val("t1_accept", hit_valid, 0);

        // inclusive bounds, miss, lower bound, no wrap near max coordinate
        all_far();
        set_tgt(0, 5, 5);
        mouse_x = 15; mouse_y = 15;
        do_click();
        check_val("t2_edge_hit", hit, 1);
        check_val("t2_edge_vec", hit_vec, 4'b0001);
        check_val("t2_edge_hcnt", hit_count, 2);
        @(negedge clk);
        mouse_x = 16; mouse_y = 15;
        do_click();
        check_val("t2_out_hit", hit, 0);
        check_val("t2_out_idx", hit_idx, 0);
        check_val("t2_out_vec", hit_vec, 0);
        check_val("t2_out_mcnt", miss_count, 1);
        @(negedge clk);
        mouse_x = 4; mouse_y = 5;
        do_click();
        check_val("t2_low_hit", hit, 0);
        check_val("t2_low_mcnt", miss_count, 2);
        @(negedge clk);
        all_far();
        set_tgt(3, 2040, 2040);
        mouse_x = 2047; mouse_y = 2047;
        do_click();
        check_val("t2_wrap_hit", hit, 1);
        check_val("t2_wrap_idx", hit_idx, 3);
        check_val("t2_wrap_vec", hit_vec, 4'b1000);
        check_val("t2_wrap_hcnt", hit_count, 3);
        @(negedge clk);
        pulse_clear();
        check_val("t2_clr_h", hit_count, 0);
        check_val("t2_clr_m", miss_count, 0);

        // overlapping targets and enable masking
        all_far();
        set_tgt(1, 95, 95);
        set_tgt(3, 100, 100);
        mouse_x = 100; mouse_y = 100;
        do_click();
        check_val("t3_ovl_vec", hit_vec, 4'b1010);
        check_val("t3_ovl_idx", hit_idx, 1);
        check_val("t3_ovl_hcnt", hit_count, 1);
        @(negedge clk);
        target_en = 4'b1101;
        do_click();
        check_val("t3_en_vec", hit_vec, 4'b1000);
        check_val("t3_en_idx", hit_idx, 3);
        check_val("t3_en_hcnt", hit_count, 2);
        @(negedge clk);
        target_en = 4'hF;

        // backpressure: hold, move inputs, second click dropped
        all_far();
        set_tgt(0, 10, 10);
        mouse_x = 12; mouse_y = 12;
        hit_ready = 1'b0;
        do_click();
        check_val("t4_vec", hit_vec, 4'b0001);
        check_val("t4_hcnt", hit_count, 3);
        n_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (hit_valid) n_valid++;
        end
        check_val("t4_hold_cycles", n_valid, 5);
        mouse_x = 300; mouse_y = 300;
        mouse_click = 1'b1;
        @(negedge clk);
        check_val("t4_drop", click_dropped, 1);
        check_val("t4_hold_valid", hit_valid, 1);
        check_val("t4_hold_vec", hit_vec, 4'b0001);
        check_val("t4_hold_idx", hit_idx, 0);
        check_val("t4_hold_hcnt", hit_count, 3);
        check_val("t4_hold_mcnt", miss_count, 0);
        hit_ready = 1'b1;
        @(negedge clk);
        check_val("t4_drop_once", click_dropped, 0);
        check_val("t4_valid_drop", hit_valid, 0);
        mouse_click = 1'b0;
        @(negedge clk);
        check_val("t4_post_mcnt", miss_count, 0);
        pulse_clear();

        // held level evaluates once
        mouse_x = 12; mouse_y = 12;
        mouse_click = 1'b1;
        n_valid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (hit_valid) n_valid++;
        end
        check_val("t5_level_once", n_valid, 1);
        check_val("t5_level_hcnt", hit_count, 1);
        mouse_click = 1'b0;
        @(negedge clk);

        // reset while in REPORT, released with click still held
        hit_ready = 1'b0;
        mouse_click = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("t5_pre_rst_valid", hit_valid, 1);
        check_val("t5_pre_rst_hcnt", hit_count, 2);
        #2;
        reset = 1'b0;
        #1;
        check_val("t5_rst_valid", hit_valid, 0);
        check_val("t5_rst_vec", hit_vec, 0);
        check_val("t5_rst_hcnt", hit_count, 0);
        @(negedge clk);
        reset = 1'b1;
        hit_ready = 1'b1;
        n_valid = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (hit_valid) n_valid++;
        end
        check_val("t5_no_event", n_valid, 0);
        check_val("t5_no_event_hcnt", hit_count, 0);
        mouse_click = 1'b0;
        @(negedge clk);

        // saturation and clear priority
        for (int k = 0; k < 5; k++) begin
            do_click();
            @(negedge clk);
        end
        check_val("t6_sat_hcnt", hit_count, 3);
        mouse_x = 400; mouse_y = 400;
        do_click();
        @(negedge clk);
        check_val("t6_miss_mcnt", miss_count, 1);
        mouse_click = 1'b1;
        @(negedge clk);
        clear_counts = 1'b1;
        mouse_click = 1'b0;
        @(negedge clk);
        clear_counts = 1'b0;
        check_val("t6_clr_valid", hit_valid, 1);
        check_val("t6_clr_hit", hit, 0);
        check_val("t6_clr_mcnt", miss_count, 0);
        check_val("t6_clr_hcnt", hit_count, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
